instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage: owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and produces the `if_id_t` bundle consumed by the decode stage. It honours decode back-pressure (`iStall`) and decode-resolved branch redirects (`iBrTrue`/`iBrTarget`), absorbing in-flight memory responses in a one-entry skid buffer so that no fetched word is lost or duplicated.

## Interface
- `ResetVector`, 32'h0000_0000, PC after reset (word aligned).
- `iClk` in 1: clock.
- `nRst` in 1: reset, synchronous, active-low.
- `iEn` in 1: global enable; low freezes all state.
- `iStall` in 1: decode cannot accept; `oID` must hold.
- `iBrTrue` in 1: redirect request from decode.
- `iBrTarget` in RegWidth: redirect target PC.
- `oMemReq` out 1: fetch request.
- `oMemAddr` out RegWidth: fetch address; stable while `oMemReq` is high and unacked.
- `iMemAck` in 1: response valid; may arrive in the same cycle as the request (zero-wait).
- `iMemData` in 32: fetched instruction, valid with `iMemAck`.
- `oID` out `if_id_t`: registered {pc, pc_plus4, instruction, valid}.
- `oMisaligned` out 1: sticky misaligned-target fault.

## Operation
- States: S_RESET, S_FETCH, S_HOLD, S_DISCARD, S_FAULT.
- S_RESET: `oMemReq`=0; on the first cycle with `nRst` high, go to S_FETCH.
- S_FETCH: `oMemReq`=1, `oMemAddr`=pc. On `iMemAck`:
  - `iStall`=0: load `oID` {pc, pc+4, iMemData, 1}; pc += 4; stay.
  - `iStall`=1: write the word into the skid buffer; pc += 4; go to S_HOLD.
- S_FETCH without ack, `iStall`=1: keep requesting. Only one outstanding request is allowed, so pc does not advance.
- S_FETCH, no ack, `iStall`=0: `oID.valid` <= 0 (bubble).
- S_HOLD: `oMemReq`=0; `oID` unchanged. When `iStall` falls, move the skid buffer into `oID` and go to S_FETCH.
- Redirect (`iBrTrue`=1) has priority over stall and ack in every state except S_RESET and S_FAULT:
  - `oID.valid` <= 0 and the skid buffer is cleared.
  - If a request is outstanding and unacked, latch the target and go to S_DISCARD. S_DISCARD keeps `oMemReq`/`oMemAddr` stable until ack, drops the data, then sets pc = target and goes to S_FETCH.
  - Otherwise (including ack in the same cycle), discard the acked word, set pc = target, and go to S_FETCH.
- A second redirect in S_DISCARD overwrites the latched target.
- `iEn`=0: no register updates; `oMemReq`/`oMemAddr` keep their current values.
- pc arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 silently.

## Timing
- Reset values: pc=`ResetVector`, state S_RESET, `oMemReq`=0, `oMisaligned`=0, skid buffer empty, `oID`={0, 4, NopInstr 32'h0000_0013, 0}.
- Reset mid-operation: an outstanding request is abandoned and `oMemReq` drops the next cycle. The memory side must tolerate this.
- Zero-wait memory: first valid `oID` appears 2 cycles after reset release, then one instruction per cycle.
- Redirect to first redirected `oID.valid`: 2 cycles with zero-wait memory when no request is pending.
- `oID` is fully registered. `oMemReq`/`oMemAddr` are decoded from state/pc only, with no combinational path from `iMemAck`.

## Configuration
- `IF_MISALIGN_CHECK_EN` defined: a redirect with `iBrTarget[1:0]`≠0 sets `oMisaligned`, clears `oID.valid`, and enters S_FAULT. S_FAULT issues no requests until reset.
- `IF_MISALIGN_CHECK_EN` undefined: `iBrTarget[1:0]` is masked to 0, S_FAULT is unreachable, and `oMisaligned` is tied 0.

## Structure
- `pipeline_types`: `if_id_t` {pc, pc_plus4, instruction, valid}, fetch state enum.
- `rv32_isa`: `RegWidth`, `NopInstr` (32'h0000_0013).
- Sub-module `if_skid_buf`: one-entry buffer with load/clear/unload and a valid flag.

## Test plan
- Zero-wait memory, reset release with `ResetVector`=0x100: `oID.pc` = 0x100, 0x104, 0x108 on consecutive cycles, valid each cycle.
- 3-cycle ack latency: `oMemAddr` stable across wait cycles and `oID.valid`=0 bubbles. Instructions arrive in order with no duplicates.
- `iStall` high for 4 cycles while an ack lands: no request during S_HOLD. After release, the buffered word at 0x108 appears once, then fetch resumes at 0x10C.
- `iBrTrue` with target 0x200 while a request to 0x110 is unacked: the 0x110 data is dropped and the next valid `oID.pc`=0x200.
- Redirect plus stall in the same cycle: `oID.valid`=0 and skid cleared, then `oID.pc`=target after `iStall` falls.
- With `IF_MISALIGN_CHECK_EN`, target 0x202: `oMisaligned`=1 and `oMemReq`=0 until `nRst` low. Without the macro, fetch goes to 0x200.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch/decode bundle, fetch FSM states and the ISA constants shared by the fetch stage.
package instr_fetch_pkg;
   localparam int RegWidth = 32;
   localparam logic [31:0] NopInstr = 32'h0000_0013;
   typedef struct packed {
      logic [RegWidth-1:0] pc;
      logic [RegWidth-1:0] pc_plus4;
      logic [31:0]         instruction;
      logic                valid;
   } if_id_t;
   typedef enum logic [2:0] {S_RESET, S_FETCH, S_HOLD, S_DISCARD, S_FAULT} fetch_state_t;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetched word that decode could not take yet.
module if_skid_buf
   import instr_fetch_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_en,
   input  logic   i_load,
   input  logic   i_clr,
   input  logic   i_unload,
   input  if_id_t i_data,
   output if_id_t o_data,
   output logic   o_valid
);
   if_id_t r_data;
   logic   r_valid;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_en) begin
         if (i_clr || i_unload) r_valid <= 1'b0;
         else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
         end
      end
   end
   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and req/ack fetch FSM feeding decode, with stall skid and branch redirect.
// Define IF_MISALIGN_CHECK_EN to trap redirects to non-word-aligned targets into a sticky fault.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [RegWidth-1:0] ResetVector = 32'h0000_0000
) (
   input  logic                iClk,
   input  logic                nRst,
   input  logic                iEn,
   input  logic                iStall,
   input  logic                iBrTrue,
   input  logic [RegWidth-1:0] iBrTarget,
   output logic                oMemReq,
   output logic [RegWidth-1:0] oMemAddr,
   input  logic                iMemAck,
   input  logic [31:0]         iMemData,
   output if_id_t              oID,
   output logic                oMisaligned
);
   fetch_state_t        r_state;
   logic [RegWidth-1:0] r_pc, r_target;
   if_id_t              r_id;
   logic [RegWidth-1:0] w_tgt, w_pc4;
   logic                w_mis, w_redir, w_skid_valid;
   if_id_t              w_fetched, w_skid_q;

   assign w_pc4     = r_pc + 32'd4;
   assign w_fetched = '{pc: r_pc, pc_plus4: w_pc4, instruction: iMemData, valid: 1'b1};
   assign w_redir   = iBrTrue && (r_state == S_FETCH || r_state == S_HOLD || r_state == S_DISCARD);

`ifdef IF_MISALIGN_CHECK_EN
   logic r_mis;
   assign w_tgt = iBrTarget;
   assign w_mis = |iBrTarget[1:0];
   always_ff @(posedge iClk) begin
      if (!nRst) r_mis <= 1'b0;
      else if (iEn && w_redir && w_mis) r_mis <= 1'b1;
   end
   assign oMisaligned = r_mis;
`else
   assign w_tgt       = iBrTarget & ~32'h3;
   assign w_mis       = 1'b0;
   assign oMisaligned = 1'b0;
`endif

   if_skid_buf u_skid (
      .i_clk    (iClk),
      .i_rst_n  (nRst),
      .i_en     (iEn),
      .i_load   (!w_redir && r_state == S_FETCH && iMemAck && iStall),
      .i_clr    (w_redir),
      .i_unload (!w_redir && r_state == S_HOLD && !iStall),
      .i_data   (w_fetched),
      .o_data   (w_skid_q),
      .o_valid  (w_skid_valid)
   );

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         r_state  <= S_RESET;
         r_pc     <= ResetVector;
         r_target <= ResetVector;
         r_id     <= '{pc: '0, pc_plus4: 32'd4, instruction: NopInstr, valid: 1'b0};
      end else if (iEn) begin
         if (w_redir) begin
            r_id.valid <= 1'b0;
            if (w_mis) r_state <= S_FAULT;
            else if (r_state == S_HOLD || iMemAck) begin
               r_pc    <= w_tgt;
               r_state <= S_FETCH;
            end else begin
               // the in-flight word must still be acked and thrown away
               r_target <= w_tgt;
               r_state  <= S_DISCARD;
            end
         end else begin
            case (r_state)
               S_RESET: r_state <= S_FETCH;
               S_FETCH: begin
                  if (iMemAck) begin
                     r_pc <= w_pc4;
                     if (iStall) r_state <= S_HOLD;
                     else r_id <= w_fetched;
                  end else if (!iStall) r_id.valid <= 1'b0;
               end
               S_HOLD: begin
                  if (!iStall) begin
                     r_id       <= w_skid_q;
                     r_id.valid <= w_skid_valid;
                     r_state    <= S_FETCH;
                  end
               end
               S_DISCARD: begin
                  if (iMemAck) begin
                     r_pc    <= r_target;
                     r_state <= S_FETCH;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign oMemReq  = r_state == S_FETCH || r_state == S_DISCARD;
   assign oMemAddr = r_pc;
   assign oID      = r_id;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of the fetch stage against a combinational instruction memory.
module tb_instr_fetch;
   import instr_fetch_pkg::*;
   logic        iClk = 1'b0;
   logic        nRst = 1'b0;
   logic        iEn = 1'b1;
   logic        iStall = 1'b0;
   logic        iBrTrue = 1'b0;
   logic [31:0] iBrTarget = '0;
   logic        oMemReq;
   logic [31:0] oMemAddr;
   logic        iMemAck = 1'b0;
   logic [31:0] iMemData;
   if_id_t      oID;
   logic        oMisaligned;
   int          n_total = 0;
   int          n_bad = 0;

   instr_fetch #(.ResetVector(32'h0000_0100)) dut (
      .iClk(iClk), .nRst(nRst), .iEn(iEn), .iStall(iStall), .iBrTrue(iBrTrue),
      .iBrTarget(iBrTarget), .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck),
      .iMemData(iMemData), .oID(oID), .oMisaligned(oMisaligned)
   );

   always #5 iClk = ~iClk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:16] ^ 16'hC0DE, a[15:0]};
   endfunction
   assign iMemData = mem_word(oMemAddr);

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic reset_dut();
      nRst = 1'b0; iEn = 1'b1; iStall = 1'b0; iBrTrue = 1'b0; iMemAck = 1'b0;
      tick(); tick();
      nRst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      nRst = 1'b0; iMemAck = 1'b1;
      tick(); tick();
      if (oMemReq !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b exp 0", oMemReq); end
      n_total++;
      if (oID.valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", oID.valid); end
      n_total++;
      if (oID.pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h exp 0", oID.pc); end
      n_total++;
      if (oID.pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL rst_pc4 got %h exp 4", oID.pc_plus4); end
      n_total++;
      if (oID.instruction !== 32'h13) begin n_bad++; $display("FAIL rst_instr got %h exp 13", oID.instruction); end
      n_total++;
      if (oMisaligned !== 1'b0) begin n_bad++; $display("FAIL rst_mis got %b exp 0", oMisaligned); end
      n_total++;
   endtask

   task automatic test_zero_wait();
      reset_dut();
      if (oMemReq !== 1'b1 || oMemAddr !== 32'h100) begin
         n_bad++; $display("FAIL zw_first_req got %b/%h exp 1/100", oMemReq, oMemAddr);
      end
      n_total++;
      if (oID.valid !== 1'b0) begin n_bad++; $display("FAIL zw_early_valid got %b exp 0", oID.valid); end
      n_total++;
      iMemAck = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] e;
         e = 32'h100 + 32'(4 * i);
         tick();
         if (oID.valid !== 1'b1 || oID.pc !== e || oID.pc_plus4 !== e + 32'd4 || oID.instruction !== mem_word(e)) begin
            n_bad++; $display("FAIL zw_word got v=%b pc=%h pc4=%h i=%h exp pc=%h", oID.valid, oID.pc, oID.pc_plus4, oID.instruction, e);
         end
         n_total++;
      end
   endtask

   task automatic test_latency();
      reset_dut();
      for (int w = 0; w < 2; w++) begin
         logic [31:0] e;
         e = 32'h100 + 32'(4 * w);
         iMemAck = 1'b0;
         for (int c = 0; c < 2; c++) begin
            if (oMemReq !== 1'b1 || oMemAddr !== e) begin
               n_bad++; $display("FAIL lat_addr got %b/%h exp 1/%h", oMemReq, oMemAddr, e);
            end
            n_total++;
            tick();
            if (oID.valid !== 1'b0) begin n_bad++; $display("FAIL lat_bubble got %b exp 0", oID.valid); end
            n_total++;
         end
         iMemAck = 1'b1;
         tick();
         if (oID.valid !== 1'b1 || oID.pc !== e || oID.instruction !== mem_word(e)) begin
            n_bad++; $display("FAIL lat_word got v=%b pc=%h i=%h exp pc=%h", oID.valid, oID.pc, oID.instruction, e);
         end
         n_total++;
      end
      iMemAck = 1'b0;
   endtask

   task automatic test_stall();
      reset_dut();
      iMemAck = 1'b1;
      tick(); tick();
      iStall = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (oID.pc !== 32'h104 || oID.valid !== 1'b1) begin
            n_bad++; $display("FAIL stall_hold got pc=%h v=%b exp 104/1", oID.pc, oID.valid);
         end
         n_total++;
         if (oMemReq !== 1'b0) begin n_bad++; $display("FAIL stall_req got %b exp 0", oMemReq); end
         n_total++;
      end
      iStall = 1'b0;
      tick();
      if (oID.pc !== 32'h108 || oID.valid !== 1'b1 || oID.instruction !== mem_word(32'h108)) begin
         n_bad++; $display("FAIL stall_skid got pc=%h v=%b i=%h exp 108", oID.pc, oID.valid, oID.instruction);
      end
      n_total++;
      if (oMemReq !== 1'b1 || oMemAddr !== 32'h10C) begin
         n_bad++; $display("FAIL stall_resume got %b/%h exp 1/10c", oMemReq, oMemAddr);
      end
      n_total++;
      tick();
      if (oID.pc !== 32'h10C || oID.valid !== 1'b1) begin
         n_bad++; $display("FAIL stall_next got pc=%h v=%b exp 10c/1", oID.pc, oID.valid);
      end
      n_total++;
   endtask

   task automatic test_redirect_pending();
      reset_dut();
      iMemAck = 1'b1;
      repeat (4) tick();
      iMemAck = 1'b0;
      tick();
      iBrTrue = 1'b1; iBrTarget = 32'h200;
      tick();
      iBrTrue = 1'b0;
      if (oID.valid !== 1'b0) begin n_bad++; $display("FAIL br_kill got %b exp 0", oID.valid); end
      n_total++;
      tick();
      if (oMemReq !== 1'b1 || oMemAddr !== 32'h110) begin
         n_bad++; $display("FAIL br_discard_addr got %b/%h exp 1/110", oMemReq, oMemAddr);
      end
      n_total++;
      iMemAck = 1'b1;
      tick();
      if (oID.valid !== 1'b0 || oMemAddr !== 32'h200) begin
         n_bad++; $display("FAIL br_drop got v=%b addr=%h exp 0/200", oID.valid, oMemAddr);
      end
      n_total++;
      tick();
      if (oID.pc !== 32'h200 || oID.valid !== 1'b1 || oID.instruction !== mem_word(32'h200)) begin
         n_bad++; $display("FAIL br_target got pc=%h v=%b exp 200/1", oID.pc, oID.valid);
      end
      n_total++;
   endtask

   task automatic test_redirect_stall();
      reset_dut();
      iMemAck = 1'b1;
      tick(); tick();
      iStall = 1'b1; iBrTrue = 1'b1; iBrTarget = 32'h300;
      tick();
      iBrTrue = 1'b0; iMemAck = 1'b0;
      if (oID.valid !== 1'b0) begin n_bad++; $display("FAIL brst_kill got %b exp 0", oID.valid); end
      n_total++;
      tick();
      if (oMemAddr !== 32'h300 || oID.valid !== 1'b0) begin
         n_bad++; $display("FAIL brst_wait got addr=%h v=%b exp 300/0", oMemAddr, oID.valid);
      end
      n_total++;
      iStall = 1'b0; iMemAck = 1'b1;
      tick();
      if (oID.pc !== 32'h300 || oID.valid !== 1'b1) begin
         n_bad++; $display("FAIL brst_target got pc=%h v=%b exp 300/1", oID.pc, oID.valid);
      end
      n_total++;
      // redirect while a word sits in the skid: that word must never surface
      reset_dut();
      iMemAck = 1'b1;
      tick();
      iStall = 1'b1;
      tick();
      iBrTrue = 1'b1; iBrTarget = 32'h400;
      tick();
      iBrTrue = 1'b0; iStall = 1'b0;
      tick();
      if (oID.pc !== 32'h400 || oID.valid !== 1'b1) begin
         n_bad++; $display("FAIL brskid_target got pc=%h v=%b exp 400/1", oID.pc, oID.valid);
      end
      n_total++;
   endtask

   task automatic test_misalign();
      reset_dut();
      iMemAck = 1'b1;
      tick();
      iBrTrue = 1'b1; iBrTarget = 32'h202;
      tick();
      iBrTrue = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      repeat (2) begin
         if (oMisaligned !== 1'b1 || oMemReq !== 1'b0 || oID.valid !== 1'b0) begin
            n_bad++; $display("FAIL mis_fault got m=%b req=%b v=%b exp 1/0/0", oMisaligned, oMemReq, oID.valid);
         end
         n_total++;
         tick();
      end
      reset_dut();
      if (oMisaligned !== 1'b0) begin n_bad++; $display("FAIL mis_clear got %b exp 0", oMisaligned); end
      n_total++;
`else
      if (oMisaligned !== 1'b0 || oMemAddr !== 32'h200) begin
         n_bad++; $display("FAIL mis_mask got m=%b addr=%h exp 0/200", oMisaligned, oMemAddr);
      end
      n_total++;
      tick();
      if (oID.pc !== 32'h200 || oID.valid !== 1'b1) begin
         n_bad++; $display("FAIL mis_target got pc=%h v=%b exp 200/1", oID.pc, oID.valid);
      end
      n_total++;
`endif
   endtask

   task automatic test_enable();
      reset_dut();
      iMemAck = 1'b1;
      tick();
      iEn = 1'b0;
      tick(); tick();
      if (oID.pc !== 32'h100 || oMemReq !== 1'b1 || oMemAddr !== 32'h104) begin
         n_bad++; $display("FAIL en_freeze got pc=%h req=%b addr=%h exp 100/1/104", oID.pc, oMemReq, oMemAddr);
      end
      n_total++;
      iEn = 1'b1;
      tick();
      if (oID.pc !== 32'h104 || oID.valid !== 1'b1) begin
         n_bad++; $display("FAIL en_resume got pc=%h v=%b exp 104/1", oID.pc, oID.valid);
      end
      n_total++;
   endtask

   task automatic test_wrap();
      reset_dut();
      iMemAck = 1'b1; iBrTrue = 1'b1; iBrTarget = 32'hFFFF_FFFC;
      tick();
      iBrTrue = 1'b0;
      tick();
      if (oID.pc !== 32'hFFFF_FFFC || oID.pc_plus4 !== 32'h0) begin
         n_bad++; $display("FAIL wrap_top got pc=%h pc4=%h exp fffffffc/0", oID.pc, oID.pc_plus4);
      end
      n_total++;
      tick();
      if (oID.pc !== 32'h0 || oID.valid !== 1'b1) begin
         n_bad++; $display("FAIL wrap_zero got pc=%h v=%b exp 0/1", oID.pc, oID.valid);
      end
      n_total++;
      iMemAck = 1'b0;
      nRst = 1'b0;
      tick();
      if (oMemReq !== 1'b0) begin n_bad++; $display("FAIL midrst_req got %b exp 0", oMemReq); end
      n_total++;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_latency();
      test_stall();
      test_redirect_pending();
      test_redirect_stall();
      test_misalign();
      test_enable();
      test_wrap();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
